// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_pkg
// Brief    : Shared encodings for the SRAM arbiter FSM, owner and strobes.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    localparam logic [0:0] c_sram_idle       = 1'b0;
    localparam logic [0:0] c_sram_busy       = 1'b1;

    localparam logic [0:0] c_sram_own_inst   = 1'b0;
    localparam logic [0:0] c_sram_own_data   = 1'b1;

    localparam logic       c_sram_strobe_off = 1'b1;
    localparam logic [3:0] c_sram_be_off     = {4{c_sram_strobe_off}};
    localparam logic [3:0] c_fetch_sel       = 4'hF;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Serialises fetch and data accesses onto one async SRAM, data
//            first, stalling the pipeline until both requests are served.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_data_o,
    output logic              inst_ready_o,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_sel_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              data_ready_o,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);
    import sram_arbiter_pkg::*;

    localparam int               c_cnt_w    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WAIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // A zero-wait write would never pulse we_n, so refuse to build it.
    if (WAIT_CYCLES < 1) begin : g_wait_check
        $error("sram_arbiter: WAIT_CYCLES must be at least 1");
    end

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [0:0]         r_owner;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_we;
    logic               r_kill;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_sel;
    logic [31:0]        r_wdata;
    logic               r_inst_done;
    logic               r_data_done;
    logic [31:0]        r_inst_data;
    logic [31:0]        r_data_rdata;

    logic w_inst_pend;
    logic w_data_pend;
    logic w_stall;
    logic w_start;
    logic w_last;
    logic w_keep;
    logic w_unused;

    assign w_inst_pend = inst_ce_i & ~r_inst_done;
    assign w_data_pend = data_ce_i & ~r_data_done;
    assign w_stall     = w_inst_pend | w_data_pend;
    assign w_start     = (r_state == c_sram_idle) & ~flush_i & w_stall;
    assign w_last      = (r_state == c_sram_busy) & (r_cnt == '0);
    // An access that saw a flush still runs its timing but reports nothing.
    assign w_keep      = w_last & ~r_kill & ~flush_i;

    assign stallreq_o   = w_stall;
    assign inst_ready_o = r_inst_done;
    assign data_ready_o = r_data_done;
    assign inst_data_o  = r_inst_data;
    assign data_rdata_o = r_data_rdata;
    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = r_wdata;

    assign w_unused = ^{inst_addr_i[31:ADDR_W+2], inst_addr_i[1:0],
                        data_addr_i[31:ADDR_W+2], data_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_sram_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_sram_idle: if (w_start) w_state_next = c_sram_busy;
            c_sram_busy: if (r_cnt == '0) w_state_next = c_sram_idle;
            default:     w_state_next = c_sram_idle;
        endcase
    end

    always_comb begin
        sram_ce_n_o = c_sram_strobe_off;
        sram_oe_n_o = c_sram_strobe_off;
        sram_we_n_o = c_sram_strobe_off;
        sram_be_n_o = c_sram_be_off;
        if (r_state == c_sram_busy) begin
            sram_ce_n_o = 1'b0;
            sram_be_n_o = ~r_sel;
            // Final write cycle releases we_n with address/data held.
            if (r_we) sram_we_n_o = (r_cnt == '0);
            else      sram_oe_n_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= c_sram_own_inst;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_kill       <= 1'b0;
            r_addr       <= '0;
            r_sel        <= '0;
            r_wdata      <= '0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
            r_inst_data  <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_start) begin
                r_kill <= 1'b0;
                r_cnt  <= c_cnt_init;
                if (w_data_pend) begin
                    r_owner <= c_sram_own_data;
                    r_addr  <= data_addr_i[ADDR_W+1:2];
                    r_sel   <= data_sel_i;
                    r_we    <= data_we_i;
                    r_wdata <= data_wdata_i;
                end else begin
                    r_owner <= c_sram_own_inst;
                    r_addr  <= inst_addr_i[ADDR_W+1:2];
                    r_sel   <= c_fetch_sel;
                    r_we    <= 1'b0;
                end
            end else if (r_state == c_sram_busy) begin
                if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_one;
                if (flush_i)     r_kill <= 1'b1;
            end

            if (!w_stall || flush_i) begin
                r_inst_done <= 1'b0;
                r_data_done <= 1'b0;
            end
            // Completion wins over the advance clear on the same edge.
            if (w_keep) begin
                if (r_owner == c_sram_own_data) begin
                    r_data_done <= 1'b1;
                    if (!r_we) r_data_rdata <= sram_rdata_i;
                end else begin
                    r_inst_done <= 1'b1;
                    r_inst_data <= sram_rdata_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed vector bench for sram_arbiter with a byte-lane SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_ready_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        flush_i;
    logic        stallreq_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i),
        .inst_data_o(inst_data_o), .inst_ready_o(inst_ready_o),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
        .flush_i(flush_i), .stallreq_o(stallreq_o),
        .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: reads while ce/oe low, lane writes at the clock
    // edge closing each we-low cycle.
    logic [31:0] mem [0:255];
    logic        mem_load;

    assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | 32'(i);
            mem[8'h04] <= 32'h3C01_1234;
            mem[8'h00] <= 32'h27BD_FFE0;
            mem[8'h81] <= 32'h1122_3344;
        end else if (!sram_ce_n_o && !sram_we_n_o) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
    end

    // Request inputs must not move across an edge that followed a stalled edge.
    logic [102:0] w_req;
    logic [102:0] prev_req;
    logic         prev_stall;
    assign w_req = {inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i};

    initial begin
        prev_req   = '0;
        prev_stall = 1'b0;
    end

    always @(posedge clk) begin
        if (rst && prev_stall && (w_req != prev_req)) viol <= viol + 1;
        prev_req   <= w_req;
        prev_stall <= stallreq_o && rst;
    end

    typedef struct {
        logic        inst_ce;
        logic [31:0] inst_addr;
        logic        data_ce;
        logic        data_we;
        logic [3:0]  sel;
        logic [31:0] daddr;
        logic [31:0] wdata;
        int          exp_stall;
        int          exp_oe;
        int          exp_we;
        int          exp_gap;
        logic [19:0] exp_first;
        logic [19:0] exp_last;
        logic [3:0]  exp_be;
        logic        exp_irdy;
        logic        exp_drdy;
        logic [31:0] exp_idata;
        logic [31:0] exp_ddata;
        int          mem_idx;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int k);
        int n, oe, we, gap;
        logic seen;
        logic [19:0] first_a, last_a;
        logic [3:0]  first_be;
        @(negedge clk);
        inst_ce_i    = v.inst_ce;
        inst_addr_i  = v.inst_addr;
        data_ce_i    = v.data_ce;
        data_we_i    = v.data_we;
        data_sel_i   = v.sel;
        data_addr_i  = v.daddr;
        data_wdata_i = v.wdata;
        #1;
        n = 0; oe = 0; we = 0; gap = 0; seen = 1'b0;
        first_a = '0; last_a = '0; first_be = 4'hF;
        while (stallreq_o && n < 40) begin
            n++;
            if (!sram_ce_n_o) begin
                if (!seen) begin
                    first_a  = sram_addr_o;
                    first_be = sram_be_n_o;
                end
                seen   = 1'b1;
                last_a = sram_addr_o;
            end else if (seen) begin
                gap++;
            end
            if (!sram_oe_n_o) oe++;
            if (!sram_we_n_o) we++;
            @(negedge clk);
            #1;
        end
        check($sformatf("v%0d_stall_cycles", k), n, v.exp_stall);
        check($sformatf("v%0d_oe_low", k), oe, v.exp_oe);
        check($sformatf("v%0d_we_low", k), we, v.exp_we);
        check($sformatf("v%0d_idle_gap", k), gap, v.exp_gap);
        check($sformatf("v%0d_first_addr", k), first_a, v.exp_first);
        check($sformatf("v%0d_first_be_n", k), first_be, v.exp_be);
        check($sformatf("v%0d_last_addr", k), last_a, v.exp_last);
        check($sformatf("v%0d_inst_ready", k), inst_ready_o, v.exp_irdy);
        check($sformatf("v%0d_data_ready", k), data_ready_o, v.exp_drdy);
        check($sformatf("v%0d_inst_data", k), inst_data_o, v.exp_idata);
        check($sformatf("v%0d_data_rdata", k), data_rdata_o, v.exp_ddata);
        check($sformatf("v%0d_mem_word", k), mem[v.mem_idx], v.exp_mem);
        // Pipeline moves on only after the advance edge.
        @(posedge clk);
        #1;
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;
        data_we_i = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; mem_load = 1'b1; flush_i = 1'b0;
        inst_ce_i = 1'b0; inst_addr_i = '0;
        data_ce_i = 1'b0; data_we_i = 1'b0; data_sel_i = '0;
        data_addr_i = '0; data_wdata_i = '0;

        //          ice  iaddr        dce  dwe  sel      daddr        wdata         stl oe we gap first    last     be_n     irdy dric idata          ddata          idx    mem
        vecs[0] = '{1'b1, 32'h10,     1'b0, 1'b0, 4'h0,    32'h0,     32'h0,         3, 2, 0, 0, 20'h4,  20'h4,  4'b0000, 1'b1, 1'b0, 32'h3C011234, 32'h00000000, 8'h04, 32'h3C011234};
        vecs[1] = '{1'b1, 32'h0,      1'b1, 1'b0, 4'hF,    32'h100,   32'h0,         6, 4, 0, 1, 20'h40, 20'h0,  4'b0000, 1'b1, 1'b1, 32'h27BDFFE0, 32'h10000040, 8'h40, 32'h10000040};
        vecs[2] = '{1'b0, 32'h0,      1'b1, 1'b1, 4'b0010, 32'h204,   32'h0000AB00,  3, 0, 1, 0, 20'h81, 20'h81, 4'b1101, 1'b0, 1'b1, 32'h27BDFFE0, 32'h10000040, 8'h81, 32'h1122AB44};
        vecs[3] = '{1'b0, 32'h0,      1'b1, 1'b0, 4'hF,    32'h204,   32'h0,         3, 2, 0, 0, 20'h81, 20'h81, 4'b0000, 1'b0, 1'b1, 32'h27BDFFE0, 32'h1122AB44, 8'h81, 32'h1122AB44};
        vecs[4] = '{1'b0, 32'h0,      1'b1, 1'b1, 4'b1001, 32'h204,   32'hAA5566BB,  3, 0, 1, 0, 20'h81, 20'h81, 4'b0110, 1'b0, 1'b1, 32'h27BDFFE0, 32'h1122AB44, 8'h81, 32'hAA22ABBB};
        vecs[5] = '{1'b1, 32'h10,     1'b1, 1'b1, 4'b0100, 32'h8,     32'h00CC0000,  6, 2, 1, 1, 20'h2,  20'h4,  4'b1011, 1'b1, 1'b1, 32'h3C011234, 32'h1122AB44, 8'h02, 32'h10CC0002};
        vecs[6] = '{1'b0, 32'h0,      1'b1, 1'b0, 4'b0001, 32'h8,     32'h0,         3, 2, 0, 0, 20'h2,  20'h2,  4'b1110, 1'b0, 1'b1, 32'h3C011234, 32'h10CC0002, 8'h02, 32'h10CC0002};

        repeat (3) @(negedge clk);
        #1;
        check("rst_ce_n", sram_ce_n_o, 1'b1);
        check("rst_oe_n", sram_oe_n_o, 1'b1);
        check("rst_we_n", sram_we_n_o, 1'b1);
        check("rst_be_n", sram_be_n_o, 4'hF);
        check("rst_addr", sram_addr_o, 20'h0);
        check("rst_wdata", sram_wdata_o, 32'h0);
        check("rst_inst_data", inst_data_o, 32'h0);
        check("rst_data_rdata", data_rdata_o, 32'h0);
        check("rst_ready", {inst_ready_o, data_ready_o}, 2'b00);
        check("rst_stall", stallreq_o, 1'b0);
        mem_load = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 7; k++) run_txn(vecs[k], k);

        // Flush lands in the final BUSY cycle of a load; the load must retry.
        @(negedge clk);
        data_ce_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("flush_busy_before", sram_oe_n_o, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush_no_ready", data_ready_o, 1'b0);
        check("flush_rdata_kept", data_rdata_o, 32'h10CC0002);
        check("flush_still_stall", stallreq_o, 1'b1);
        n = 0;
        while (!data_ready_o && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("flush_retry_cycles", n, 3);
        check("flush_retry_rdata", data_rdata_o, 32'h10000040);
        check("flush_retry_stall", stallreq_o, 1'b0);
        @(posedge clk);
        #1;
        data_ce_i = 1'b0;

        // Reset asserted while the store's we_n is low.
        @(negedge clk);
        data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'hF;
        data_addr_i = 32'h300; data_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        check("rstmid_we_low", sram_we_n_o, 1'b0);
        rst = 1'b0;
        #1;
        check("rstmid_strobes", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}, 7'h7F);
        check("rstmid_addr", sram_addr_o, 20'h0);
        check("rstmid_wdata", sram_wdata_o, 32'h0);
        check("rstmid_rdata", {inst_data_o, data_rdata_o} == 64'h0, 1'b1);
        check("rstmid_stall", stallreq_o, 1'b1);
        repeat (2) @(negedge clk);
        check("rstmid_write_lost", mem[8'hC0], 32'h100000C0);
        rst = 1'b1;
        #1;
        n = 0;
        while (stallreq_o && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("rstrel_stall_cycles", n, 3);
        check("rstrel_data_ready", data_ready_o, 1'b1);
        check("rstrel_mem_word", mem[8'hC0], 32'hCAFEF00D);
        @(posedge clk);
        #1;
        data_ce_i = 1'b0; data_we_i = 1'b0;

        // Quiet bus: no requests for ten cycles.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle_c%0d", c),
                  {stallreq_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}, 8'h7F);
        end

        check("req_stability", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one external asynchronous SRAM between the instruction-fetch port and the data-access port of the 5-stage MIPS core.
- Sits between cpu_path (rom_* / ram_* buses) and the board SRAM pins.
- Serialises accesses with data priority, generates multi-cycle SRAM timing, and raises stallreq_o to ctrl until every request of the current pipeline cycle is served.

Parameters:
- ADDR_W, 20, SRAM word-address width; sram_addr_o = addr_i[ADDR_W+1:2].
- WAIT_CYCLES, 1, extra SRAM cycles per access; an access holds the bus for WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- inst_ce_i  in  1  fetch request; held while stallreq_o=1.
- inst_addr_i  in  32  fetch byte address.
- inst_data_o  out  32  latched fetch data.
- inst_ready_o  out  1  fetch served this pipeline cycle.
- data_ce_i  in  1  load/store request; held while stallreq_o=1.
- data_we_i  in  1  1 = store.
- data_sel_i  in  4  byte enables, bit i = byte lane i.
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  store data.
- data_rdata_o  out  32  latched load data.
- data_ready_o  out  1  data served this pipeline cycle.
- flush_i  in  1  exception flush from ctrl.
- stallreq_o  out  1  stall request to ctrl.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM strobes, active-low.
- sram_be_n_o  out  4  byte enables, active-low.
- sram_addr_o  out  ADDR_W  word address.
- sram_wdata_o  out  32  write data; tri-state handled at top level.
- sram_rdata_i  in  32  read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, inst_done=data_done=0.
  - All sram_*_n_o = 1 (sram_be_n_o=4'hF), sram_addr_o=0, sram_wdata_o=0.
  - inst_data_o=data_rdata_o=0.
  - Reset mid-access deasserts strobes immediately; the in-flight write is lost.
- stallreq_o (combinational from registered flags) = (inst_ce_i & ~inst_done) | (data_ce_i & ~data_done).
- inst_ready_o = inst_done; data_ready_o = data_done.
- Advance edge: any rising edge with stallreq_o=0. It clears both done flags. Read data registers keep their value until the next completion.
- FSM states: IDLE and BUSY; registered owner bit (DATA/INST) and cnt of width clog2(WAIT_CYCLES+1).
- IDLE:
  - If data_ce_i & ~data_done, start a data access.
  - Else if inst_ce_i & ~inst_done, start a fetch.
  - Else stay in IDLE.
  - On start: register address, byte enables (fetch uses 4'hF), write data, we; cnt=WAIT_CYCLES; go to BUSY.
- BUSY:
  - sram_ce_n_o=0.
  - Read: sram_oe_n_o=0.
  - Write: sram_we_n_o=0 while cnt!=0; on the final cycle we_n_o=1 with address and data still held (hold time).
  - When cnt==0: a read latches sram_rdata_i into inst_data_o or data_rdata_o; the owner's done flag is set; go to IDLE with strobes returning to 1.
  - Otherwise cnt decrements.
- Latency: request seen in IDLE at cycle 0; SRAM active cycles 1..WAIT_CYCLES+1; done visible at cycle WAIT_CYCLES+2.
- A single request stalls WAIT_CYCLES+2 cycles. A fetch and a load in the same cycle stall 2*(WAIT_CYCLES+2) cycles: data first, one IDLE turnaround cycle, then the fetch.
- WAIT_CYCLES=0 with a write: we_n_o stays 1 for the whole access. This setting is illegal and is checked by an elaboration assertion.
- flush_i=1:
  - Clears both done flags.
  - An in-flight write completes its full timing.
  - An in-flight read completes its timing but does not set done or update the output register.
  - ctrl has flush priority, so stallreq_o during flush is don't-care to ctrl but still follows the formula.
- Requests dropped (ce_i=0) while the FSM is BUSY: the access completes and the done flag is set; it is cleared at the next advance edge.
- Request inputs changing while stallreq_o=1 is a protocol violation; the bench asserts stability.

Decomposition:
- Add to defines.v:
  - SRAM FSM state encodings (SramIdle, SramBusy).
  - Owner encodings (SramOwnInst, SramOwnData).
  - SramStrobeOff (1'b1).
- Single module, no sub-module. The cnt/strobe generator is too small to split.

Test Plan:
- WAIT_CYCLES=1, inst_ce_i=1 @0x00000010, SRAM word 4 = 0x3C011234 -> stallreq_o high 3 cycles, sram_addr_o=4, sram_oe_n_o low 2 cycles, inst_data_o=0x3C011234, inst_ready_o=1 in the 4th cycle.
- Fetch @0x0 plus load @0x100 in the same cycle -> data access first (sram_addr_o=0x40), one IDLE cycle, fetch (addr 0); stallreq_o high 6 cycles; both ready=1 in the same cycle.
- Store sel=4'b0010, data 0x0000AB00 @0x204 -> sram_be_n_o=4'b1101, we_n_o low 1 cycle then high 1 cycle, addr 0x81; only byte 1 changes in the SRAM model.
- flush_i pulse during the 2nd BUSY cycle of a load -> data_rdata_o unchanged, data_done=0, load re-issued after flush if data_ce_i is still 1.
- rst driven 0 mid-store -> all strobes 1 within the same cycle (asynchronous), outputs 0, FSM in IDLE; after release, the first request completes normally.
- No requests for 10 cycles -> stallreq_o=0, all strobes 1 throughout.
